// File: rtl/npu_dot_engine.sv
// Serial dot-product engine: unsigned activations times signed weights via one shift-add
// multiplier, followed by arithmetic right shift, optional ReLU and output saturation.
module npu_dot_engine #(
   parameter int unsigned DATA_W  = 4,
   parameter int unsigned VEC_LEN = 4,
   parameter int unsigned ACC_W   = 12,
   parameter int unsigned OUT_W   = 8,
   parameter int unsigned SHIFT_W = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               relu_en,
   input  logic [SHIFT_W-1:0] out_shift,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [DATA_W-1:0]  in_weight,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   out_data,
   output logic               overflow,
   output logic               busy
);

   localparam int unsigned BitCntW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int unsigned ElemCntW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   // Comparison width holds both the shifted accumulator and the unsigned output ceiling.
   localparam int unsigned CmpW     = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 2;

   localparam logic signed [CmpW-1:0] UMax = {{(CmpW - OUT_W){1'b0}}, {OUT_W{1'b1}}};
   localparam logic signed [CmpW-1:0] SMax = {{(CmpW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [CmpW-1:0] SMin = {{(CmpW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StMul,
      StFinal,
      StDone
   } state_e;

   state_e                    state_q, state_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [ElemCntW-1:0]       elem_cnt_q, elem_cnt_d;
   logic [BitCntW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]         data_q, data_d;
   logic [DATA_W-1:0]         weight_q, weight_d;
   logic                      relu_q, relu_d;
   logic [SHIFT_W-1:0]        shift_q, shift_d;
   logic [OUT_W-1:0]          out_data_q, out_data_d;
   logic                      overflow_q, overflow_d;

   logic [ACC_W-1:0]          addend;
   logic signed [ACC_W-1:0]   acc_shifted;
   logic signed [CmpW-1:0]    s_ext;
   logic [OUT_W-1:0]          sat_data;
   logic                      sat_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         acc_q      <= '0;
         elem_cnt_q <= '0;
         bit_cnt_q  <= '0;
         data_q     <= '0;
         weight_q   <= '0;
         relu_q     <= 1'b0;
         shift_q    <= '0;
         out_data_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         elem_cnt_q <= elem_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         data_q     <= data_d;
         weight_q   <= weight_d;
         relu_q     <= relu_d;
         shift_q    <= shift_d;
         out_data_q <= out_data_d;
         overflow_q <= overflow_d;
      end
   end

   // Post-processing of the finished accumulator: floor shift, then ReLU or signed clamp.
   always_comb begin
      acc_shifted = acc_q >>> shift_q;
      s_ext       = {{(CmpW - ACC_W){acc_shifted[ACC_W-1]}}, acc_shifted};
      sat_data    = s_ext[OUT_W-1:0];
      sat_ovf     = 1'b0;
      if (relu_q) begin
         if (s_ext < 0) begin
            sat_data = '0;
         end else if (s_ext > UMax) begin
            sat_data = '1;
            sat_ovf  = 1'b1;
         end
      end else begin
         if (s_ext > SMax) begin
            sat_data = SMax[OUT_W-1:0];
            sat_ovf  = 1'b1;
         end else if (s_ext < SMin) begin
            sat_data = SMin[OUT_W-1:0];
            sat_ovf  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      elem_cnt_d = elem_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      data_d     = data_q;
      weight_d   = weight_q;
      relu_d     = relu_q;
      shift_d    = shift_q;
      out_data_d = out_data_q;
      overflow_d = overflow_q;
      addend     = ACC_W'(data_q) << bit_cnt_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StLoad;
               acc_d      = '0;
               elem_cnt_d = '0;
               relu_d     = relu_en;
               shift_d    = out_shift;
            end
         end
         StLoad: begin
            if (in_valid) begin
               data_d    = in_data;
               weight_d  = in_weight;
               bit_cnt_d = '0;
               state_d   = StMul;
            end
         end
         StMul: begin
            // The weight MSB carries negative significance in two's complement.
            if (weight_q[0]) begin
               if (bit_cnt_q == BitCntW'(DATA_W - 1)) begin
                  acc_d = acc_q - addend;
               end else begin
                  acc_d = acc_q + addend;
               end
            end
            weight_d  = weight_q >> 1;
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
            if (bit_cnt_q == BitCntW'(DATA_W - 1)) begin
               if (elem_cnt_q == ElemCntW'(VEC_LEN - 1)) begin
                  state_d = StFinal;
               end else begin
                  elem_cnt_d = elem_cnt_q + ElemCntW'(1);
                  state_d    = StLoad;
               end
            end
         end
         StFinal: begin
            out_data_d = sat_data;
            overflow_d = sat_ovf;
            state_d    = StDone;
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign in_ready  = (state_q == StLoad);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign out_data  = out_data_q;
   assign overflow  = overflow_q;

endmodule
